// File: rtl/ex_stage_md.sv
// Execute stage: latches the decode bus, computes the ALU result, drives the data SRAM request,
// and runs an iterative multiply/divide unit that owns HI/LO.
module ex_stage_md #(
    parameter int unsigned STALL_W   = 6,
    parameter int unsigned MD_CYCLES = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic [166:0]       id_to_ex_bus,
    output logic [75:0]        ex_to_mem_bus,
    output logic [75:0]        ex_to_id_bus,
    output logic               stall_en,
    output logic               stallreq_md,
    output logic               data_sram_en,
    output logic [3:0]         data_sram_wen,
    output logic [31:0]        data_sram_addr,
    output logic [31:0]        data_sram_wdata
);
    localparam int unsigned CNT_W = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;

    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;

    logic [166:0] ex_q;
    logic [31:0]  hi_q, lo_q;
    md_state_e    state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [63:0]  acc_q, mcand_q;
    logic [31:0]  mplier_q, rs_q;
    logic         div_q, div0_q, neg_q, rem_neg_q, md_done_q;

    always_ff @(posedge clk) begin
        if (rst)                      ex_q <= '0;
        else if (stall[2] && !stall[3]) ex_q <= '0;
        else if (!stall[2])           ex_q <= id_to_ex_bus;
    end

    logic [7:0]  hilo_op;
    logic [31:0] pc, inst, rdata1, rdata2;
    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2, ram_wen;
    logic        ram_en, rf_we, sel_rf_res;
    logic [4:0]  rf_waddr;

    assign hilo_op    = ex_q[166:159];
    assign pc         = ex_q[158:127];
    assign inst       = ex_q[126:95];
    assign alu_op     = ex_q[94:83];
    assign sel_src1   = ex_q[82:80];
    assign sel_src2   = ex_q[79:76];
    assign ram_en     = ex_q[75];
    assign ram_wen    = ex_q[74:71];
    assign rf_we      = ex_q[70];
    assign rf_waddr   = ex_q[69:65];
    assign sel_rf_res = ex_q[64];
    assign rdata1     = ex_q[63:32];
    assign rdata2     = ex_q[31:0];

    logic [31:0] src1, src2, alu_res, result;

    assign src1 = ({32{sel_src1[0]}} & rdata1)
                | ({32{sel_src1[1]}} & pc)
                | ({32{sel_src1[2]}} & {27'b0, inst[10:6]});
    assign src2 = ({32{sel_src2[0]}} & rdata2)
                | ({32{sel_src2[1]}} & {{16{inst[15]}}, inst[15:0]})
                | ({32{sel_src2[2]}} & 32'd8)
                | ({32{sel_src2[3]}} & {16'b0, inst[15:0]});

    // One-hot alu_op: each enabled unit ORs its result in
    always_comb begin
        alu_res = '0;
        if (alu_op[11]) alu_res = alu_res | (src1 + src2);
        if (alu_op[10]) alu_res = alu_res | (src1 - src2);
        if (alu_op[9])  alu_res = alu_res | {31'b0, $signed(src1) < $signed(src2)};
        if (alu_op[8])  alu_res = alu_res | {31'b0, src1 < src2};
        if (alu_op[7])  alu_res = alu_res | (src1 & src2);
        if (alu_op[6])  alu_res = alu_res | ~(src1 | src2);
        if (alu_op[5])  alu_res = alu_res | (src1 | src2);
        if (alu_op[4])  alu_res = alu_res | (src1 ^ src2);
        if (alu_op[3])  alu_res = alu_res | (src2 << src1[4:0]);
        if (alu_op[2])  alu_res = alu_res | (src2 >> src1[4:0]);
        if (alu_op[1])  alu_res = alu_res | 32'($signed(src2) >>> src1[4:0]);
        if (alu_op[0])  alu_res = alu_res | {src2[15:0], 16'b0};
    end

    assign result = hilo_op[3] ? hi_q : (hilo_op[2] ? lo_q : alu_res);

    assign ex_to_mem_bus   = {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, result};
    assign ex_to_id_bus    = ex_to_mem_bus;
    assign stall_en        = sel_rf_res & rf_we;
    assign data_sram_en    = ram_en;
    assign data_sram_wen   = ram_wen;
    assign data_sram_addr  = alu_res;
    assign data_sram_wdata = rdata2;

    // Multiply/divide operand conditioning
    logic        md_div, md_signed, rs_neg, rt_neg, md_start;
    logic [31:0] rs_abs, rt_abs;

    assign md_div    = hilo_op[5] | hilo_op[4];
    assign md_signed = hilo_op[7] | hilo_op[5];
    assign rs_neg    = md_signed & rdata1[31];
    assign rt_neg    = md_signed & rdata2[31];
    assign rs_abs    = rs_neg ? -rdata1 : rdata1;
    assign rt_abs    = rt_neg ? -rdata2 : rdata2;
    // md_done_q blocks re-issue if a finished op is held in EX by a downstream stall
    assign md_start  = (|hilo_op[7:4]) && !md_done_q;
    assign stallreq_md = ((state_q == MD_IDLE) && md_start) || (state_q == MD_BUSY);

    logic [63:0] mul_next, div_next, prod;
    logic [32:0] rem_sh, rem_new;
    logic        div_ge;
    logic [31:0] quot, rem, div_lo, div_hi;

    assign mul_next = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
    assign rem_sh   = acc_q[63:31];
    assign div_ge   = rem_sh >= {1'b0, mcand_q[31:0]};
    assign rem_new  = div_ge ? (rem_sh - {1'b0, mcand_q[31:0]}) : rem_sh;
    assign div_next = {rem_new[31:0], acc_q[30:0], div_ge};

    assign prod   = neg_q ? -acc_q : acc_q;
    assign quot   = acc_q[31:0];
    assign rem    = acc_q[63:32];
    assign div_lo = div0_q ? 32'hFFFF_FFFF : (neg_q ? -quot : quot);
    assign div_hi = div0_q ? rs_q : (rem_neg_q ? -rem : rem);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            rs_q      <= '0;
            div_q     <= 1'b0;
            div0_q    <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            md_done_q <= 1'b0;
        end else begin
            md_done_q <= stall[2] && (md_done_q || (state_q == MD_DONE));
            case (state_q)
                MD_IDLE: begin
                    if (md_start) begin
                        acc_q     <= md_div ? {32'b0, rs_abs} : 64'd0;
                        mcand_q   <= {32'b0, md_div ? rt_abs : rs_abs};
                        mplier_q  <= rt_abs;
                        rs_q      <= rdata1;
                        div_q     <= md_div;
                        div0_q    <= md_div && (rdata2 == 32'd0);
                        neg_q     <= rs_neg ^ rt_neg;
                        rem_neg_q <= rs_neg;
                        cnt_q     <= '0;
                        state_q   <= MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    acc_q <= div_q ? div_next : mul_next;
                    if (!div_q) begin
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                    end
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(MD_CYCLES - 1)) state_q <= MD_DONE;
                end
                MD_DONE: state_q <= MD_IDLE;
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    // HI/LO: multiply/divide result at DONE, otherwise mthi/mtlo when EX advances
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state_q == MD_DONE) begin
            {hi_q, lo_q} <= div_q ? {div_hi, div_lo} : prod;
        end else if (!stall[3]) begin
            if (hilo_op[1]) hi_q <= rdata1;
            if (hilo_op[0]) lo_q <= rdata1;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{stall[1:0], stall[STALL_W-1:4], inst[31:16]};
endmodule

// File: tb/tb_ex_stage_md.sv
// Scoreboard bench for ex_stage_md: a driver issues instructions and queues expected results from a
// behavioural model; a negedge monitor compares whatever leaves EX.
module tb_ex_stage_md;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [5:0]   stall, stall_ext;
    logic [166:0] id_bus;
    logic [75:0]  mem_bus, id_fwd_bus;
    logic         stall_en, stallreq_md, sram_en;
    logic [3:0]   sram_wen;
    logic [31:0]  sram_addr, sram_wdata;

    // Pipeline control freezes PC..EX while the multiply/divide unit is busy
    assign stall = stallreq_md ? 6'b001111 : stall_ext;

    ex_stage_md #(.STALL_W(6), .MD_CYCLES(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .id_to_ex_bus(id_bus),
        .ex_to_mem_bus(mem_bus), .ex_to_id_bus(id_fwd_bus),
        .stall_en(stall_en), .stallreq_md(stallreq_md),
        .data_sram_en(sram_en), .data_sram_wen(sram_wen),
        .data_sram_addr(sram_addr), .data_sram_wdata(sram_wdata)
    );

    typedef struct {
        logic [75:0] bus;
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        stall_en;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          vectors = 0;
    int          errors  = 0;
    int          md_run  = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [31:0] pc_ctr = 32'h0000_1000;

    task automatic chk(input string nm, input logic [75:0] act, input logic [75:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] alu_model(input logic [11:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        if (op[11]) return a + b;
        if (op[10]) return a - b;
        if (op[9])  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        if (op[8])  return (a < b) ? 32'd1 : 32'd0;
        if (op[7])  return a & b;
        if (op[6])  return ~(a | b);
        if (op[5])  return a | b;
        if (op[4])  return a ^ b;
        if (op[3])  return b << a[4:0];
        if (op[2])  return b >> a[4:0];
        if (op[1])  return 32'($signed(b) >>> a[4:0]);
        if (op[0])  return {b[15:0], 16'h0000};
        return 32'd0;
    endfunction

    task automatic wait_md_idle();
        int guard = 0;
        while (stallreq_md) begin
            @(posedge clk); #1;
            guard++;
            if (guard > 200) begin
                chk("md_timeout", 76'(stallreq_md), 76'd0);
                break;
            end
        end
    endtask

    // ctl = {ram_en, ram_wen[3:0], rf_we, sel_rf_res}
    task automatic issue(input logic [7:0] hop, input logic [11:0] aop, input logic [2:0] s1,
                         input logic [3:0] s2, input logic [31:0] inst, input logic [31:0] rd1,
                         input logic [31:0] rd2, input logic [6:0] ctl, input logic push,
                         input logic use_c, input logic [31:0] cres);
        logic [31:0] pc, a, b, alu, res;
        logic [4:0]  wa;
        logic [63:0] p;
        longint      sq, sr;
        exp_t        e;
        wait_md_idle();
        pc_ctr = pc_ctr + 32'd4;
        pc = pc_ctr;
        wa = pc[6:2];
        a = s1[0] ? rd1 : s1[1] ? pc : s1[2] ? {27'b0, inst[10:6]} : 32'd0;
        b = s2[0] ? rd2 : s2[1] ? {{16{inst[15]}}, inst[15:0]} : s2[2] ? 32'd8
          : s2[3] ? {16'b0, inst[15:0]} : 32'd0;
        alu = alu_model(aop, a, b);
        res = hop[3] ? m_hi : hop[2] ? m_lo : alu;
        if (use_c) res = cres;
        e.bus      = {pc, ctl[6], ctl[5:2], ctl[0], ctl[1], wa, res};
        e.en       = ctl[6];
        e.wen      = ctl[5:2];
        e.addr     = alu;
        e.wdata    = rd2;
        e.stall_en = ctl[1] & ctl[0];
        if (push) sb.push_back(e);
        if (hop[7]) begin
            p = 64'(longint'($signed(rd1)) * longint'($signed(rd2)));
            {m_hi, m_lo} = p;
        end
        if (hop[6]) begin
            p = {32'b0, rd1} * {32'b0, rd2};
            {m_hi, m_lo} = p;
        end
        if (hop[5] || hop[4]) begin
            if (rd2 == 32'd0) begin
                m_lo = 32'hFFFF_FFFF;
                m_hi = rd1;
            end else if (hop[5]) begin
                sq = longint'($signed(rd1)) / longint'($signed(rd2));
                sr = longint'($signed(rd1)) % longint'($signed(rd2));
                m_lo = sq[31:0];
                m_hi = sr[31:0];
            end else begin
                m_lo = rd1 / rd2;
                m_hi = rd1 % rd2;
            end
        end
        if (hop[1]) m_hi = rd1;
        if (hop[0]) m_lo = rd1;
        id_bus    = {hop, pc, inst, aop, s1, s2, ctl[6], ctl[5:2], ctl[1], wa, ctl[0], rd1, rd2};
        stall_ext = 6'b000000;
        @(posedge clk); #1;
        id_bus = '0;
    endtask

    // Decode presents a live instruction, but stall[2]=Stop/stall[3]=NoStop must inject a bubble
    task automatic bubble();
        logic [191:0] tmp;
        wait_md_idle();
        tmp = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        id_bus    = tmp[166:0];
        stall_ext = 6'b000111;
        @(posedge clk); #1;
        chk("bubble_bus", mem_bus, 76'd0);
        chk("bubble_md", 76'(stallreq_md), 76'd0);
        stall_ext = 6'b000000;
        id_bus    = '0;
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 4))
            0: return 32'($urandom_range(0, 20));
            1: return -32'($urandom_range(1, 20));
            2: return 32'd0;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: an instruction leaves EX whenever it is not held by the multiply/divide unit
    always @(negedge clk) begin
        if (rst) begin
            md_run = 0;
        end else begin
            if (stallreq_md) begin
                md_run++;
            end else if (md_run != 0) begin
                chk("md_stall_len", 76'(md_run), 76'd33);
                md_run = 0;
            end
            if (!stallreq_md && mem_bus[75:44] != 32'd0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", mem_bus, 76'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("ex_to_mem_bus", mem_bus, mon_e.bus);
                    chk("ex_to_id_bus", id_fwd_bus, mon_e.bus);
                    chk("sram_en", 76'(sram_en), 76'(mon_e.en));
                    chk("sram_wen", 76'(sram_wen), 76'(mon_e.wen));
                    chk("sram_addr", 76'(sram_addr), 76'(mon_e.addr));
                    chk("sram_wdata", 76'(sram_wdata), 76'(mon_e.wdata));
                    chk("stall_en", 76'(stall_en), 76'(mon_e.stall_en));
                end
            end
        end
    end

    localparam logic [11:0] OP_ADD = 12'h800, OP_SLT = 12'h200, OP_SLTU = 12'h100, OP_SLL = 12'h008;
    localparam logic [6:0]  C_ALU = 7'b0000010, C_SW = 7'b1111100, C_LW = 7'b1000011, C_NONE = 7'b0;

    initial begin
        rst = 1'b1; stall_ext = '0; id_bus = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bus", mem_bus, 76'd0);
        chk("rst_md", 76'(stallreq_md), 76'd0);
        chk("rst_sram", {7'b0, sram_en, sram_wen, sram_addr, sram_wdata}, 76'd0);
        chk("rst_stall_en", 76'(stall_en), 76'd0);
        rst = 1'b0;

        issue(8'h00, OP_ADD,  3'b001, 4'b0010, 32'h0000_FFFF, 32'd5, 32'd0, C_ALU, 1'b1, 1'b1, 32'd4);
        issue(8'h00, OP_SLT,  3'b001, 4'b0001, 32'd0, 32'hFFFF_FFFF, 32'd1, C_ALU, 1'b1, 1'b1, 32'd1);
        issue(8'h00, OP_SLTU, 3'b001, 4'b0001, 32'd0, 32'hFFFF_FFFF, 32'd1, C_ALU, 1'b1, 1'b1, 32'd0);
        issue(8'h00, OP_SLL,  3'b100, 4'b0001, 32'h0000_0100, 32'd0, 32'd1, C_ALU, 1'b1, 1'b1, 32'h10);
        issue(8'h80, 12'h0, 3'b001, 4'b0001, 32'd0, -32'd3, 32'd7, C_NONE, 1'b1, 1'b1, 32'd0);
        issue(8'h04, 12'h0, 3'b001, 4'b0001, 32'd0, 32'd0, 32'd0, C_ALU, 1'b1, 1'b1, 32'hFFFF_FFEB);
        issue(8'h08, 12'h0, 3'b001, 4'b0001, 32'd0, 32'd0, 32'd0, C_ALU, 1'b1, 1'b1, 32'hFFFF_FFFF);
        issue(8'h20, 12'h0, 3'b001, 4'b0001, 32'd0, -32'd7, 32'd2, C_NONE, 1'b1, 1'b1, 32'd0);
        issue(8'h04, 12'h0, 3'b001, 4'b0001, 32'd0, 32'd0, 32'd0, C_ALU, 1'b1, 1'b1, 32'hFFFF_FFFD);
        issue(8'h08, 12'h0, 3'b001, 4'b0001, 32'd0, 32'd0, 32'd0, C_ALU, 1'b1, 1'b1, 32'hFFFF_FFFF);
        issue(8'h10, 12'h0, 3'b001, 4'b0001, 32'd0, 32'd9, 32'd0, C_NONE, 1'b1, 1'b1, 32'd0);
        issue(8'h04, 12'h0, 3'b001, 4'b0001, 32'd0, 32'd0, 32'd0, C_ALU, 1'b1, 1'b1, 32'hFFFF_FFFF);
        issue(8'h08, 12'h0, 3'b001, 4'b0001, 32'd0, 32'd0, 32'd0, C_ALU, 1'b1, 1'b1, 32'd9);
        issue(8'h00, OP_ADD, 3'b001, 4'b0010, 32'h0000_0008, 32'h100, 32'hDEAD_BEEF, C_SW, 1'b1, 1'b1, 32'h108);
        issue(8'h00, OP_ADD, 3'b001, 4'b0010, 32'h0000_0008, 32'h100, 32'd0, C_LW, 1'b1, 1'b1, 32'h108);
        bubble();

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                bubble();
            end else begin
                issue(($urandom_range(0, 5) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00,
                      12'(1 << $urandom_range(0, 11)), 3'(1 << $urandom_range(0, 2)),
                      4'(1 << $urandom_range(0, 3)), $urandom, rnd32(), rnd32(),
                      7'($urandom), 1'b1, 1'b0, 32'd0);
            end
        end

        // Reset in the middle of a multiply must abort it and clear HI/LO
        issue(8'h80, 12'h0, 3'b001, 4'b0001, 32'd0, 32'd123, 32'd456, C_NONE, 1'b0, 1'b0, 32'd0);
        repeat (11) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_md", 76'(stallreq_md), 76'd0);
        chk("abort_bus", mem_bus, 76'd0);
        rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
        issue(8'h08, 12'h0, 3'b001, 4'b0001, 32'd0, 32'd0, 32'd0, C_ALU, 1'b1, 1'b1, 32'd0);
        issue(8'h04, 12'h0, 3'b001, 4'b0001, 32'd0, 32'd0, 32'd0, C_ALU, 1'b1, 1'b1, 32'd0);

        repeat (5) @(posedge clk);
        #1;
        chk("sb_drained", 76'(sb.size()), 76'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/ex_stage_md.md
Name: ex_stage_md

Overview:
- Execute stage of the 5-stage MIPS pipeline, directly downstream of instruction decode.
- Latches the decode-to-execute bus and computes the ALU result.
- Drives the data SRAM request and forwards its result back to decode.
- Owns the HI/LO registers and a 32-iteration multiply/divide unit that stalls the pipeline while busy.

Parameters:
STALL_W, 6, width of stall vector (bit 0 = PC, 1 = IF/ID, 2 = ID/EX, 3 = EX/MEM, 4 = MEM/WB)
MD_CYCLES, 32, iterations per multiply/divide

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall  in  STALL_W  pipeline stall vector, 1 = Stop
id_to_ex_bus  in  167  {hilo_op[7:0], pc[31:0], inst[31:0], alu_op[11:0], sel_src1[2:0], sel_src2[3:0], ram_en, ram_wen[3:0], rf_we, rf_waddr[4:0], sel_rf_res, rdata1[31:0], rdata2[31:0]}
ex_to_mem_bus  out  76  {pc, ram_en, ram_wen[3:0], sel_rf_res, rf_we, rf_waddr[4:0], result[31:0]}
ex_to_id_bus  out  76  same content as ex_to_mem_bus
stall_en  out  1  load in EX (sel_rf_res & rf_we); decode uses it for load-use stall
stallreq_md  out  1  multiply/divide busy stall request
data_sram_en  out  1  data SRAM enable
data_sram_wen  out  4  byte write enables
data_sram_addr  out  32  data SRAM address
data_sram_wdata  out  32  store data

Behaviour:
Reset and interface:
- Reset is synchronous, active-high on rst; clock is clk.
- Reset clears the input register, HI, LO, FSM (IDLE) and counter; outputs are 0.

Input register:
- stall[2]=Stop and stall[3]=NoStop: load 167'b0 (bubble).
- stall[2]=NoStop: load id_to_ex_bus.
- Otherwise: hold.

ALU (combinational):
- alu_op is one-hot {add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui}.
- src1: [0] rdata1, [1] pc, [2] zero-extended inst[10:6].
- src2: [0] rdata2, [1] sign-extended inst[15:0], [2] 32'd8, [3] zero-extended inst[15:0].
- Shifts use src1[4:0] as amount and src2 as data; lui gives {src2[15:0], 16'b0}.
- add/sub wrap modulo 2^32, no overflow trap.
- slt is a signed compare; sltu is an unsigned compare; both return 0 or 1.

result mux:
- mfhi gives HI; mflo gives LO; otherwise the ALU output.

Memory request:
- data_sram_en = ram_en; data_sram_wen = ram_wen; data_sram_addr = ALU output; data_sram_wdata = rdata2.

hilo_op bits:
- [7] mult, [6] multu, [5] div, [4] divu, [3] mfhi, [2] mflo, [1] mthi, [0] mtlo.
- mthi/mtlo write rdata1 into HI/LO at the clock edge where the instruction is in EX and stall[3]=NoStop.

MD FSM states: IDLE, BUSY, DONE.
- IDLE with any of hilo_op[7:4] set: capture operands, counter=0, go BUSY; stallreq_md=1 this cycle.
- BUSY: one iteration per cycle, counter+1, stallreq_md=1; at counter=MD_CYCLES-1 go DONE.
- DONE: stallreq_md=0; write HI/LO at this edge; go IDLE. The same instruction leaves EX at this edge and must not re-issue.
- Total stall is 1+MD_CYCLES cycles; the op occupies EX for MD_CYCLES+2 cycles.

Multiply:
- Shift-add over |rs|, |rt| for signed ops; the 64-bit product is negated if the signs differ.
- {HI, LO} = product.

Divide:
- Radix-2 restoring over absolute values.
- LO = quotient, negated if the signs differ.
- HI = remainder, taking the dividend's sign.
- Divisor 0: no exception; LO=32'hFFFF_FFFF, HI=rs (both div and divu).

Ordering:
- An mfhi/mflo immediately after a MD op reads the updated HI/LO, since the write happens before it enters EX.
- Reset asserted in BUSY aborts the op; HI/LO become 0.

Test Plan:
1. addiu: rdata1=32'h0000_0005, imm=16'hFFFF -> result=32'h0000_0004, rf_we=1 on ex_to_mem_bus one cycle after load.
2. slt rs=32'hFFFF_FFFF, rt=1 -> 1; sltu same operands -> 0; sll sa=4 of 32'h1 -> 32'h10.
3. mult rs=-3, rt=7 -> stallreq_md high exactly 33 cycles; then mflo -> 32'hFFFF_FFEB, mfhi -> 32'hFFFF_FFFF.
4. div rs=-7, rt=2 -> LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF; divu rs=9, rt=0 -> LO=32'hFFFF_FFFF, HI=9.
5. sw with base=32'h100, imm=8, rdata2=32'hDEAD_BEEF -> data_sram_en=1, wen=4'hF, addr=32'h108, wdata=32'hDEAD_BEEF; lw -> stall_en=1.
6. Assert rst at BUSY count 10 -> FSM IDLE, stallreq_md=0, HI=LO=0 next cycle; stall[2]=Stop, stall[3]=NoStop -> ex_to_mem_bus all-zero bubble.
